// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl
// Execute-stage control for a single-cycle MIPS-I Harvard CPU. This one block
// holds the main decoder, the ALU-op decoder, the ALU, the branch comparator
// and the HI/LO register pair. HI/LO is the only state; everything else is
// combinational on the current instruction word.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset (clears HI/LO)
//   clk_enable, active   step enable and CPU-running flag; both must be high,
//                        with reset low, for any enable to assert
//   instr                current instruction word
//   reg_a, reg_b         GPR[rs] and GPR[rt]
//   alu_result           ALU output, also the data address
//   branch_taken         branch condition of the current branch instruction
//   byte_offset          alu_result[1:0]
//   pc_sel               0 pc+4, 1 branch target, 2 jump target, 3 reg_a
//   data_read/data_write load and store strobes
//   byte_enable          store lane enables
//   reg_write_enable     GPR write enable
//   reg_addr_sel         0 rt, 1 rd, 2 $31
//   reg_data_sel         0 alu_result, 1 memory word, 2 extended byte/half,
//                        3 link pc
//   alu_sel              ALU B input: 0 reg_b, 1 extended immediate
//   signextend_sel       1 sign-extend, 0 zero-extend (immediate and load data)
//   lwlr_sel             bit1 LWL/LWR merge path, bit0 LWL
//   hi, lo               HI/LO registers
module mips_exec_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr,
  input  logic [31:0] reg_a,
  input  logic [31:0] reg_b,
  output logic [31:0] alu_result,
  output logic        branch_taken,
  output logic [1:0]  byte_offset,
  output logic [1:0]  pc_sel,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  byte_enable,
  output logic        reg_write_enable,
  output logic [1:0]  reg_addr_sel,
  output logic [1:0]  reg_data_sel,
  output logic        alu_sel,
  output logic        signextend_sel,
  output logic [1:0]  lwlr_sel,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_HI, ALU_LO
  } alu_op_t;

  typedef enum logic [2:0] {
    HL_NONE, HL_MULT, HL_MULTU, HL_DIV, HL_DIVU, HL_MTHI, HL_MTLO
  } hilo_op_t;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ
  } br_cond_t;

  typedef enum logic [1:0] {ST_NONE, ST_B, ST_H, ST_W} store_t;

  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG} pc_kind_t;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_field, shamt;
  logic [15:0] imm16;

  assign opcode   = instr[31:26];
  assign rt_field = instr[20:16];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];

  // g: the single qualifier for every side effect this block can cause
  logic g;
  assign g = clk_enable & active & ~reset;

  alu_op_t  alu_op;
  hilo_op_t hilo_op;
  br_cond_t br_cond;
  store_t   store_kind;
  pc_kind_t pc_kind;
  logic     dec_write, dec_read, var_shift, zext_imm;

  // Main decoder. Everything defaults to "no effect" so unknown encodings
  // fall out with all enables low and ALU_ZERO. zext_imm is kept separate
  // from signextend_sel because LBU/LHU zero-extend their data but still
  // form the address with a sign-extended offset.
  always_comb begin
    alu_op         = ALU_ZERO;
    hilo_op        = HL_NONE;
    br_cond        = BR_NONE;
    store_kind     = ST_NONE;
    pc_kind        = PC_SEQ;
    dec_write      = 1'b0;
    dec_read       = 1'b0;
    var_shift      = 1'b0;
    zext_imm       = 1'b0;
    reg_addr_sel   = 2'd0;
    reg_data_sel   = 2'd0;
    alu_sel        = 1'b0;
    signextend_sel = 1'b1;
    lwlr_sel       = 2'b00;
    case (opcode)
      6'h00: begin
        reg_addr_sel = 2'd1;
        case (funct)
          6'h00: begin alu_op = ALU_SLL; dec_write = 1'b1; end
          6'h02: begin alu_op = ALU_SRL; dec_write = 1'b1; end
          6'h03: begin alu_op = ALU_SRA; dec_write = 1'b1; end
          6'h04: begin alu_op = ALU_SLL; var_shift = 1'b1; dec_write = 1'b1; end
          6'h06: begin alu_op = ALU_SRL; var_shift = 1'b1; dec_write = 1'b1; end
          6'h07: begin alu_op = ALU_SRA; var_shift = 1'b1; dec_write = 1'b1; end
          6'h08: pc_kind = PC_REG;
          6'h09: begin
            pc_kind      = PC_REG;
            dec_write    = 1'b1;
            reg_data_sel = 2'd3;
          end
          6'h10: begin alu_op = ALU_HI; dec_write = 1'b1; end
          6'h11: hilo_op = HL_MTHI;
          6'h12: begin alu_op = ALU_LO; dec_write = 1'b1; end
          6'h13: hilo_op = HL_MTLO;
          6'h18: hilo_op = HL_MULT;
          6'h19: hilo_op = HL_MULTU;
          6'h1A: hilo_op = HL_DIV;
          6'h1B: hilo_op = HL_DIVU;
          6'h21: begin alu_op = ALU_ADD;  dec_write = 1'b1; end
          6'h23: begin alu_op = ALU_SUB;  dec_write = 1'b1; end
          6'h24: begin alu_op = ALU_AND;  dec_write = 1'b1; end
          6'h25: begin alu_op = ALU_OR;   dec_write = 1'b1; end
          6'h26: begin alu_op = ALU_XOR;  dec_write = 1'b1; end
          6'h27: begin alu_op = ALU_NOR;  dec_write = 1'b1; end
          6'h2A: begin alu_op = ALU_SLT;  dec_write = 1'b1; end
          6'h2B: begin alu_op = ALU_SLTU; dec_write = 1'b1; end
          default: reg_addr_sel = 2'd1;
        endcase
      end
      // REGIMM: the link variants write $31 regardless of the outcome
      6'h01: begin
        alu_op = ALU_SUB;
        case (rt_field)
          5'h00: begin pc_kind = PC_BRANCH; br_cond = BR_LTZ; end
          5'h01: begin pc_kind = PC_BRANCH; br_cond = BR_GEZ; end
          5'h10, 5'h11: begin
            pc_kind      = PC_BRANCH;
            br_cond      = rt_field[0] ? BR_GEZ : BR_LTZ;
            dec_write    = 1'b1;
            reg_addr_sel = 2'd2;
            reg_data_sel = 2'd3;
          end
          default: alu_op = ALU_ZERO;
        endcase
      end
      6'h02: pc_kind = PC_JUMP;
      6'h03: begin
        pc_kind      = PC_JUMP;
        dec_write    = 1'b1;
        reg_addr_sel = 2'd2;
        reg_data_sel = 2'd3;
      end
      6'h04: begin pc_kind = PC_BRANCH; br_cond = BR_EQ;  alu_op = ALU_SUB; end
      6'h05: begin pc_kind = PC_BRANCH; br_cond = BR_NE;  alu_op = ALU_SUB; end
      6'h06: begin pc_kind = PC_BRANCH; br_cond = BR_LEZ; alu_op = ALU_SUB; end
      6'h07: begin pc_kind = PC_BRANCH; br_cond = BR_GTZ; alu_op = ALU_SUB; end
      6'h09: begin alu_op = ALU_ADD;  alu_sel = 1'b1; dec_write = 1'b1; end
      6'h0A: begin alu_op = ALU_SLT;  alu_sel = 1'b1; dec_write = 1'b1; end
      6'h0B: begin alu_op = ALU_SLTU; alu_sel = 1'b1; dec_write = 1'b1; end
      6'h0C, 6'h0D, 6'h0E: begin
        alu_op         = (opcode == 6'h0C) ? ALU_AND :
                         (opcode == 6'h0D) ? ALU_OR : ALU_XOR;
        alu_sel        = 1'b1;
        zext_imm       = 1'b1;
        signextend_sel = 1'b0;
        dec_write      = 1'b1;
      end
      6'h0F: begin alu_op = ALU_LUI; alu_sel = 1'b1; dec_write = 1'b1; end
      6'h20, 6'h21, 6'h24, 6'h25: begin
        alu_op         = ALU_ADD;
        alu_sel        = 1'b1;
        dec_read       = 1'b1;
        dec_write      = 1'b1;
        reg_data_sel   = 2'd2;
        signextend_sel = ~opcode[2];
      end
      6'h23: begin
        alu_op = ALU_ADD; alu_sel = 1'b1;
        dec_read = 1'b1; dec_write = 1'b1; reg_data_sel = 2'd1;
      end
      6'h22, 6'h26: begin
        alu_op = ALU_ADD; alu_sel = 1'b1;
        dec_read = 1'b1; dec_write = 1'b1; reg_data_sel = 2'd1;
        lwlr_sel = {1'b1, ~opcode[2]};
      end
      6'h28: begin alu_op = ALU_ADD; alu_sel = 1'b1; store_kind = ST_B; end
      6'h29: begin alu_op = ALU_ADD; alu_sel = 1'b1; store_kind = ST_H; end
      6'h2B: begin alu_op = ALU_ADD; alu_sel = 1'b1; store_kind = ST_W; end
      default: alu_op = ALU_ZERO;
    endcase
  end

  logic [31:0] imm_ext, alu_b;
  logic [4:0]  shift_amt;

  assign imm_ext   = zext_imm ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  assign alu_b     = alu_sel ? imm_ext : reg_b;
  assign shift_amt = var_shift ? reg_a[4:0] : shamt;

  // ALU. Shifts always operate on reg_b; SLTIU compares against the
  // sign-extended immediate as an unsigned value.
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_result = reg_a + alu_b;
      ALU_SUB:  alu_result = reg_a - alu_b;
      ALU_AND:  alu_result = reg_a & alu_b;
      ALU_OR:   alu_result = reg_a | alu_b;
      ALU_XOR:  alu_result = reg_a ^ alu_b;
      ALU_NOR:  alu_result = ~(reg_a | alu_b);
      ALU_SLT:  alu_result = {31'h0, $signed(reg_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'h0, reg_a < alu_b};
      ALU_LUI:  alu_result = {imm16, 16'h0000};
      ALU_SLL:  alu_result = reg_b << shift_amt;
      ALU_SRL:  alu_result = reg_b >> shift_amt;
      ALU_SRA:  alu_result = $unsigned($signed(reg_b) >>> shift_amt);
      ALU_HI:   alu_result = hi;
      ALU_LO:   alu_result = lo;
      default:  alu_result = 32'h0;
    endcase
  end

  assign byte_offset = alu_result[1:0];

  // Branch comparator: all compares are signed, so sign bit plus a zero
  // test covers every relation against zero.
  logic a_zero;
  assign a_zero = (reg_a == 32'h0);

  always_comb begin
    branch_taken = 1'b0;
    case (br_cond)
      BR_EQ:   branch_taken = (reg_a == reg_b);
      BR_NE:   branch_taken = (reg_a != reg_b);
      BR_LEZ:  branch_taken = reg_a[31] | a_zero;
      BR_GTZ:  branch_taken = ~reg_a[31] & ~a_zero;
      BR_LTZ:  branch_taken = reg_a[31];
      BR_GEZ:  branch_taken = ~reg_a[31];
      default: branch_taken = 1'b0;
    endcase
  end

  // Gated side-effect outputs. A halfword store at an odd halfword offset
  // enables no lanes.
  always_comb begin
    pc_sel           = 2'd0;
    reg_write_enable = 1'b0;
    data_read        = 1'b0;
    data_write       = 1'b0;
    byte_enable      = 4'b0000;
    if (g) begin
      reg_write_enable = dec_write;
      data_read        = dec_read;
      data_write       = (store_kind != ST_NONE);
      case (pc_kind)
        PC_BRANCH: pc_sel = branch_taken ? 2'd1 : 2'd0;
        PC_JUMP:   pc_sel = 2'd2;
        PC_REG:    pc_sel = 2'd3;
        default:   pc_sel = 2'd0;
      endcase
      case (store_kind)
        ST_W:    byte_enable = 4'b1111;
        ST_H:    byte_enable = (byte_offset == 2'd0) ? 4'b0011 :
                               (byte_offset == 2'd2) ? 4'b1100 : 4'b0000;
        ST_B:    byte_enable = 4'b0001 << byte_offset;
        default: byte_enable = 4'b0000;
      endcase
    end
  end

  // Multiply/divide results, computed ahead of the HI/LO register
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign prod_s = $unsigned($signed({{32{reg_a[31]}}, reg_a}) *
                            $signed({{32{reg_b[31]}}, reg_b}));
  assign prod_u = {32'h0, reg_a} * {32'h0, reg_b};

  // SV signed division truncates toward zero and the remainder follows the
  // dividend, which is exactly MIPS DIV; a zero divisor is caught below.
  always_comb begin
    quot_s = 32'h0;
    rem_s  = 32'h0;
    quot_u = 32'h0;
    rem_u  = 32'h0;
    if (reg_b != 32'h0) begin
      quot_s = $unsigned($signed(reg_a) / $signed(reg_b));
      rem_s  = $unsigned($signed(reg_a) % $signed(reg_b));
      quot_u = reg_a / reg_b;
      rem_u  = reg_a % reg_b;
    end
  end

  // HI/LO register pair
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else if (clk_enable && active) begin
      case (hilo_op)
        HL_MULT:  {hi, lo} <= prod_s;
        HL_MULTU: {hi, lo} <= prod_u;
        HL_DIV:   if (reg_b != 32'h0) begin lo <= quot_s; hi <= rem_s; end
        HL_DIVU:  if (reg_b != 32'h0) begin lo <= quot_u; hi <= rem_u; end
        HL_MTHI:  hi <= reg_a;
        HL_MTLO:  lo <= reg_a;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// tb_mips_exec_ctrl
// Directed-vector bench for mips_exec_ctrl. Each vector is driven on the
// falling edge and checked shortly after; HI/LO results are checked one
// rising edge later. Expected values are hand-computed constants.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset, clk_enable, active;
  logic [31:0] instr, reg_a, reg_b;
  logic [31:0] alu_result, hi, lo;
  logic        branch_taken, data_read, data_write, reg_write_enable;
  logic        alu_sel, signextend_sel;
  logic [1:0]  byte_offset, pc_sel, reg_addr_sel, reg_data_sel, lwlr_sel;
  logic [3:0]  byte_enable;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_exec_ctrl dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr(instr), .reg_a(reg_a), .reg_b(reg_b),
    .alu_result(alu_result), .branch_taken(branch_taken),
    .byte_offset(byte_offset), .pc_sel(pc_sel),
    .data_read(data_read), .data_write(data_write),
    .byte_enable(byte_enable), .reg_write_enable(reg_write_enable),
    .reg_addr_sel(reg_addr_sel), .reg_data_sel(reg_data_sel),
    .alu_sel(alu_sel), .signextend_sel(signextend_sel),
    .lwlr_sel(lwlr_sel), .hi(hi), .lo(lo)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one instruction with its operands on the falling edge
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    instr = i;
    reg_a = a;
    reg_b = b;
    #1;
  endtask

  // Let one rising edge pass, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; active = 1'b1;
    instr = 32'h0; reg_a = 32'h0; reg_b = 32'h0;

    // Reset held with an ADDIU and an SW present: nothing may be enabled
    applyStimulus(itype(6'h09, 5'd1, 5'd2, 16'h0001), 32'd5, 32'd0);
    tick();
    tick();
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_rwe", 32'(reg_write_enable), 32'h0);
    checkOutput("reset_pc", 32'(pc_sel), 32'h0);
    applyStimulus(itype(6'h2B, 5'd1, 5'd2, 16'h0000), 32'd0, 32'd0);
    checkOutput("reset_dw", 32'(data_write), 32'h0);
    checkOutput("reset_be", 32'(byte_enable), 32'h0);
    reset = 1'b0;

    // ADDIU 5 + (-1)
    applyStimulus(itype(6'h09, 5'd1, 5'd2, 16'hFFFF), 32'd5, 32'd0);
    checkOutput("addiu_res", alu_result, 32'd4);
    checkOutput("addiu_alusel", 32'(alu_sel), 32'd1);
    checkOutput("addiu_ras", 32'(reg_addr_sel), 32'd0);
    checkOutput("addiu_rwe", 32'(reg_write_enable), 32'd1);
    checkOutput("addiu_sext", 32'(signextend_sel), 32'd1);

    // R-type ALU ops and shifts
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 32'd5, 32'd7);
    checkOutput("subu_res", alu_result, 32'hFFFFFFFE);
    checkOutput("subu_ras", 32'(reg_addr_sel), 32'd1);
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1);
    checkOutput("slt_res", alu_result, 32'd1);
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1);
    checkOutput("sltu_res", alu_result, 32'd0);
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'h0F0F0000, 32'h000000F0);
    checkOutput("nor_res", alu_result, 32'hF0F0FF0F);
    applyStimulus(rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 32'd0, 32'h80000000);
    checkOutput("sra_res", alu_result, 32'hF8000000);
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h06), 32'd4, 32'h80000000);
    checkOutput("srlv_res", alu_result, 32'h08000000);
    applyStimulus(rtype(5'd0, 5'd2, 5'd3, 5'd8, 6'h00), 32'd0, 32'h000000AB);
    checkOutput("sll_res", alu_result, 32'h0000AB00);

    // Immediate ops
    applyStimulus(itype(6'h0F, 5'd0, 5'd2, 16'h1234), 32'd0, 32'd0);
    checkOutput("lui_res", alu_result, 32'h12340000);
    applyStimulus(itype(6'h0D, 5'd1, 5'd2, 16'h8000), 32'd1, 32'd0);
    checkOutput("ori_res", alu_result, 32'h00008001);
    checkOutput("ori_sext", 32'(signextend_sel), 32'd0);
    applyStimulus(itype(6'h0B, 5'd1, 5'd2, 16'hFFFF), 32'd5, 32'd0);
    checkOutput("sltiu_res", alu_result, 32'd1);
    applyStimulus(itype(6'h0A, 5'd1, 5'd2, 16'hFFFF), 32'd5, 32'd0);
    checkOutput("slti_res", alu_result, 32'd0);

    // Multiply / divide
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'hFFFFFFFD, 32'd7);
    checkOutput("mult_rwe", 32'(reg_write_enable), 32'd0);
    tick();
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFEB);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h19), 32'hFFFFFFFF, 32'd2);
    tick();
    checkOutput("multu_hi", hi, 32'h00000001);
    checkOutput("multu_lo", lo, 32'hFFFFFFFE);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1A), 32'hFFFFFFF9, 32'd2);
    tick();
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1B), 32'd7, 32'd2);
    tick();
    checkOutput("divu_lo", lo, 32'd3);
    checkOutput("divu_hi", hi, 32'd1);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1A), 32'd100, 32'd0);
    tick();
    checkOutput("div0_lo", lo, 32'd3);
    checkOutput("div0_hi", hi, 32'd1);
    applyStimulus(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h11), 32'h12345678, 32'd0);
    tick();
    checkOutput("mthi_hi", hi, 32'h12345678);
    applyStimulus(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h10), 32'd0, 32'd0);
    checkOutput("mfhi_res", alu_result, 32'h12345678);
    checkOutput("mfhi_rwe", 32'(reg_write_enable), 32'd1);
    applyStimulus(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12), 32'd0, 32'd0);
    checkOutput("mflo_res", alu_result, 32'd3);

    // Inactive CPU: no enables, HI/LO hold
    active = 1'b0;
    applyStimulus(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h13), 32'h0000AAAA, 32'd0);
    tick();
    checkOutput("inact_lo", lo, 32'd3);
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd1, 32'd2);
    checkOutput("inact_rwe", 32'(reg_write_enable), 32'd0);
    checkOutput("inact_res", alu_result, 32'd3);
    applyStimulus(itype(6'h28, 5'd1, 5'd2, 16'h0002), 32'h1001, 32'd0);
    checkOutput("inact_dw", 32'(data_write), 32'd0);
    checkOutput("inact_be", 32'(byte_enable), 32'd0);
    active = 1'b1;

    // Loads and stores
    applyStimulus(itype(6'h28, 5'd1, 5'd2, 16'h0002), 32'h1001, 32'd0);
    checkOutput("sb_addr", alu_result, 32'h1003);
    checkOutput("sb_be", 32'(byte_enable), 32'b1000);
    checkOutput("sb_dw", 32'(data_write), 32'd1);
    checkOutput("sb_off", 32'(byte_offset), 32'd3);
    checkOutput("sb_rwe", 32'(reg_write_enable), 32'd0);
    applyStimulus(itype(6'h29, 5'd1, 5'd2, 16'h0002), 32'h1000, 32'd0);
    checkOutput("sh2_be", 32'(byte_enable), 32'b1100);
    applyStimulus(itype(6'h29, 5'd1, 5'd2, 16'h0000), 32'h1000, 32'd0);
    checkOutput("sh0_be", 32'(byte_enable), 32'b0011);
    applyStimulus(itype(6'h2B, 5'd1, 5'd2, 16'h0004), 32'h1000, 32'd0);
    checkOutput("sw_be", 32'(byte_enable), 32'b1111);
    applyStimulus(itype(6'h23, 5'd1, 5'd2, 16'hFFFC), 32'h100, 32'd0);
    checkOutput("lw_addr", alu_result, 32'h000000FC);
    checkOutput("lw_dr", 32'(data_read), 32'd1);
    checkOutput("lw_rds", 32'(reg_data_sel), 32'd1);
    checkOutput("lw_be", 32'(byte_enable), 32'd0);
    applyStimulus(itype(6'h24, 5'd1, 5'd2, 16'hFFFF), 32'h100, 32'd0);
    checkOutput("lbu_addr", alu_result, 32'h000000FF);
    checkOutput("lbu_rds", 32'(reg_data_sel), 32'd2);
    checkOutput("lbu_sext", 32'(signextend_sel), 32'd0);
    checkOutput("lbu_rwe", 32'(reg_write_enable), 32'd1);
    applyStimulus(itype(6'h22, 5'd1, 5'd2, 16'h0001), 32'h100, 32'd0);
    checkOutput("lwl_sel", 32'(lwlr_sel), 32'b11);
    applyStimulus(itype(6'h26, 5'd1, 5'd2, 16'h0001), 32'h100, 32'd0);
    checkOutput("lwr_sel", 32'(lwlr_sel), 32'b10);

    // Branches
    applyStimulus(itype(6'h01, 5'd1, 5'h11, 16'h0010), 32'hFFFFFFFF, 32'd0);
    checkOutput("bgezal_bt", 32'(branch_taken), 32'd0);
    checkOutput("bgezal_pc", 32'(pc_sel), 32'd0);
    checkOutput("bgezal_rwe", 32'(reg_write_enable), 32'd1);
    checkOutput("bgezal_ras", 32'(reg_addr_sel), 32'd2);
    checkOutput("bgezal_rds", 32'(reg_data_sel), 32'd3);
    applyStimulus(itype(6'h01, 5'd1, 5'h10, 16'h0010), 32'hFFFFFFFF, 32'd0);
    checkOutput("bltzal_pc", 32'(pc_sel), 32'd1);
    applyStimulus(itype(6'h05, 5'd1, 5'd2, 16'h0010), 32'd1, 32'd2);
    checkOutput("bne_pc", 32'(pc_sel), 32'd1);
    checkOutput("bne_rwe", 32'(reg_write_enable), 32'd0);
    applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd1, 32'd2);
    checkOutput("beq_pc", 32'(pc_sel), 32'd0);
    applyStimulus(itype(6'h06, 5'd1, 5'd0, 16'h0010), 32'd0, 32'd0);
    checkOutput("blez_pc", 32'(pc_sel), 32'd1);
    applyStimulus(itype(6'h07, 5'd1, 5'd0, 16'h0010), 32'd0, 32'd0);
    checkOutput("bgtz_pc", 32'(pc_sel), 32'd0);

    // Jumps
    applyStimulus({6'h02, 26'h0000100}, 32'd0, 32'd0);
    checkOutput("j_pc", 32'(pc_sel), 32'd2);
    checkOutput("j_rwe", 32'(reg_write_enable), 32'd0);
    applyStimulus({6'h03, 26'h0000100}, 32'd0, 32'd0);
    checkOutput("jal_ras", 32'(reg_addr_sel), 32'd2);
    checkOutput("jal_rwe", 32'(reg_write_enable), 32'd1);
    applyStimulus(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'h400, 32'd0);
    checkOutput("jr_pc", 32'(pc_sel), 32'd3);
    applyStimulus(rtype(5'd1, 5'd0, 5'd5, 5'd0, 6'h09), 32'h400, 32'd0);
    checkOutput("jalr_pc", 32'(pc_sel), 32'd3);
    checkOutput("jalr_ras", 32'(reg_addr_sel), 32'd1);
    checkOutput("jalr_rds", 32'(reg_data_sel), 32'd3);

    // Unknown opcode and unknown funct
    applyStimulus(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd9, 32'd9);
    checkOutput("unk_res", alu_result, 32'd0);
    checkOutput("unk_rwe", 32'(reg_write_enable), 32'd0);
    checkOutput("unk_pc", 32'(pc_sel), 32'd0);
    checkOutput("unk_dw", 32'(data_write), 32'd0);
    applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd9, 32'd9);
    checkOutput("unkf_res", alu_result, 32'd0);
    checkOutput("unkf_rwe", 32'(reg_write_enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
